vote_controller: RTL
====================

Name: vote_controller

Overview:
- Ballot sequencer between the per-candidate debounced vote pulses and the tally store of the EVM.
- Arms a single ballot on an official's enable, accepts exactly one candidate vote, and rejects multi-press.
- Increments that candidate's saturating counter, then enforces a lockout period before it can be re-armed.
- In result mode, serves any candidate's count to the display path.

Parameters:
- NUM_CAND, 4, number of candidates (2..16); each candidate has one valid_vote bit.
- CNT_W, 8, width of each per-candidate vote counter.
- LOCKOUT_CYCLES, 100000000, clock cycles spent in LOCKOUT after a recorded vote (>=1).

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high; clears all state and counters.
- valid_vote  in  NUM_CAND  one-cycle debounced vote pulses, bit i = candidate i.
- ballot_en  in  1  official's arm pulse.
- result_mode  in  1  1 = results/admin mode, 0 = polling mode.
- result_sel  in  $clog2(NUM_CAND)  candidate index to display in result mode.
- clear_counts  in  1  admin clear of all counters.
- ready  out  1  high while ARMED (ballot open LED).
- busy  out  1  high while in RECORD or LOCKOUT.
- vote_recorded  out  1  one-cycle pulse when a vote is committed.
- vote_reject  out  1  one-cycle pulse on a multi-press rejection.
- recorded_cand  out  $clog2(NUM_CAND)  index of the last committed vote; holds its value.
- count_out  out  CNT_W  registered count of candidate result_sel.

Behaviour:
- All outputs are registered. On reset:
  - state = IDLE; all counters, timer and recorded_cand = 0.
  - ready, busy, vote_recorded, vote_reject, count_out = 0.
- Reset has priority over every other input. Reset mid-LOCKOUT or mid-RECORD aborts the operation and also clears the counters.
- IDLE state:
  - ready = 0.
  - ballot_en = 1 with result_mode = 0 → ARMED on the next edge.
  - ballot_en with result_mode = 1 is ignored.
- ARMED state:
  - ready = 1.
  - result_mode = 1 → IDLE (ballot cancelled, no count).
  - Otherwise, exactly one valid_vote bit set → RECORD, latching that index.
  - Two or more bits set → stay ARMED; vote_reject = 1 on the next cycle.
  - Zero bits set → stay ARMED.
  - ballot_en while ARMED is ignored.
- RECORD state (exactly one cycle):
  - count[idx] <= count[idx] + 1, saturating at 2^CNT_W-1 (no wrap).
  - vote_recorded = 1 and recorded_cand = idx, both visible during the cycle after RECORD.
  - Timer <= 0; next state LOCKOUT.
  - Latency from the valid_vote edge to the vote_recorded pulse is 2 cycles.
- LOCKOUT state:
  - busy = 1; valid_vote, ballot_en and clear_counts are ignored.
  - Timer increments each cycle; when timer == LOCKOUT_CYCLES-1 → IDLE.
  - Total busy duration = 1 + LOCKOUT_CYCLES cycles.
  - The next ballot requires a fresh ballot_en; the controller never re-arms on its own.
- result_mode change:
  - Takes effect in IDLE/ARMED only.
  - A vote already in RECORD/LOCKOUT completes normally.
- clear_counts:
  - Acts only when state = IDLE and result_mode = 1: zeroes all counters in one cycle.
  - Ignored in every other case.
- count_out:
  - Equals count[result_sel] when result_mode = 1, else 0, with 1-cycle latency.
  - result_sel >= NUM_CAND yields 0.
  - A clear or increment is reflected in the following cycle's sample.
- Simultaneous events:
  - clear_counts together with ballot_en in IDLE with result_mode = 1: the clear wins; no arm occurs because result_mode = 1.

Test Plan:
- Bench uses LOCKOUT_CYCLES = 4, NUM_CAND = 4, CNT_W = 8.
- Arm and single vote:
  - Stimulus: ballot_en pulse, then valid_vote = 4'b0100 one cycle.
  - Required: ready drops; vote_recorded pulses 2 cycles after the vote; recorded_cand = 2.
  - Required: busy is high for 5 cycles, then IDLE. In result mode with result_sel = 2, count_out = 1.
- Unarmed press and lockout press:
  - Stimulus: valid_vote = 4'b0001 in IDLE, and again during LOCKOUT.
  - Required: no vote_recorded; count[0] unchanged.
- Multi-press:
  - Stimulus: while ARMED, valid_vote = 4'b0011.
  - Required: vote_reject pulses 1 cycle; ready stays 1. A following 4'b0010 records candidate 1.
- Saturation:
  - Stimulus: 257 ballots for candidate 3.
  - Required: count_out = 255, with no wrap to 0.
- Clear and cancel:
  - Stimulus: arm, then set result_mode = 1.
  - Required: returns to IDLE, no count.
  - Stimulus: clear_counts in IDLE with result_mode = 1.
  - Required: all counts read 0. Also verify clear_counts with result_mode = 0 has no effect.
- Reset mid-LOCKOUT:
  - Stimulus: assert reset 1 cycle during LOCKOUT.
  - Required: next cycle busy = 0, ready = 0, all counts = 0; ballot_en then arms normally.

Source files
------------

// File: rtl/vote_if.sv
// Ballot bus between the vote/admin front panel and the vote controller.
interface vote_if #(
  parameter int unsigned NUM_CAND = 4,
  parameter int unsigned CNT_W    = 8
);
  localparam int unsigned SEL_W = $clog2(NUM_CAND);

  logic [NUM_CAND-1:0] valid_vote;
  logic                ballot_en;
  logic                result_mode;
  logic [SEL_W-1:0]    result_sel;
  logic                clear_counts;
  logic                ready;
  logic                busy;
  logic                vote_recorded;
  logic                vote_reject;
  logic [SEL_W-1:0]    recorded_cand;
  logic [CNT_W-1:0]    count_out;

  modport master (
    output valid_vote, ballot_en, result_mode, result_sel, clear_counts,
    input  ready, busy, vote_recorded, vote_reject, recorded_cand, count_out
  );

  modport slave (
    input  valid_vote, ballot_en, result_mode, result_sel, clear_counts,
    output ready, busy, vote_recorded, vote_reject, recorded_cand, count_out
  );
endinterface

// File: rtl/vote_controller.sv
// Ballot sequencer: arm, accept one vote, tally with saturation, lock out,
// and serve per-candidate counts in result mode.
module vote_controller #(
  parameter int unsigned NUM_CAND       = 4,
  parameter int unsigned CNT_W          = 8,
  parameter int unsigned LOCKOUT_CYCLES = 100000000
) (
  input logic  clock,
  input logic  reset,
  vote_if.slave bus
);
  localparam int unsigned SEL_W = $clog2(NUM_CAND);
  localparam int unsigned SEL_N = 1 << SEL_W;
  localparam int unsigned TMR_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(LOCKOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, ARMED, RECORD, LOCKOUT} state_t;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] count_q [NUM_CAND];
  logic [CNT_W-1:0] count_d [NUM_CAND];
  logic [CNT_W-1:0] count_ext [SEL_N];

  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             rec_q, rec_d;
  logic             rej_q, rej_d;
  logic [SEL_W-1:0] rec_cand_q, rec_cand_d;
  logic [CNT_W-1:0] count_out_q, count_out_d;

  logic             one_hot_c;
  logic             multi_c;
  logic [SEL_W-1:0] press_idx_c;

  assign one_hot_c = ($countones(bus.valid_vote) == 1);
  assign multi_c   = ($countones(bus.valid_vote) > 1);

  // Index of the pressed candidate; only meaningful when one_hot_c.
  always_comb begin
    press_idx_c = '0;
    for (int unsigned i = 0; i < NUM_CAND; i++) begin
      if (bus.valid_vote[i]) press_idx_c = SEL_W'(i);
    end
  end

  // Pad the count table so out-of-range selects read zero.
  always_comb begin
    for (int unsigned i = 0; i < SEL_N; i++) count_ext[i] = '0;
    for (int unsigned i = 0; i < NUM_CAND; i++) count_ext[i] = count_q[i];
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    idx_d      = idx_q;
    count_d    = count_q;
    rec_d      = 1'b0;
    rej_d      = 1'b0;
    rec_cand_d = rec_cand_q;

    unique case (state_q)
      IDLE: begin
        if (bus.result_mode) begin
          if (bus.clear_counts) begin
            for (int unsigned i = 0; i < NUM_CAND; i++) count_d[i] = '0;
          end
        end else if (bus.ballot_en) begin
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (bus.result_mode) begin
          state_d = IDLE;
        end else if (one_hot_c) begin
          state_d = RECORD;
          idx_d   = press_idx_c;
        end else if (multi_c) begin
          rej_d = 1'b1;
        end
      end
      RECORD: begin
        if (count_q[idx_q] != CNT_MAX) count_d[idx_q] = count_q[idx_q] + CNT_W'(1);
        rec_d      = 1'b1;
        rec_cand_d = idx_q;
        timer_d    = '0;
        state_d    = LOCKOUT;
      end
      LOCKOUT: begin
        if (timer_q == TMR_LAST) state_d = IDLE;
        else                     timer_d = timer_q + TMR_W'(1);
      end
      default: state_d = IDLE;
    endcase

    ready_d     = (state_d == ARMED);
    busy_d      = (state_d == RECORD) || (state_d == LOCKOUT);
    count_out_d = bus.result_mode ? count_ext[bus.result_sel] : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      timer_q     <= '0;
      idx_q       <= '0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      rec_q       <= 1'b0;
      rej_q       <= 1'b0;
      rec_cand_q  <= '0;
      count_out_q <= '0;
      for (int unsigned i = 0; i < NUM_CAND; i++) count_q[i] <= '0;
    end else begin
      timer_q     <= timer_d;
      idx_q       <= idx_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      rec_q       <= rec_d;
      rej_q       <= rej_d;
      rec_cand_q  <= rec_cand_d;
      count_out_q <= count_out_d;
      for (int unsigned i = 0; i < NUM_CAND; i++) count_q[i] <= count_d[i];
    end
  end

  assign bus.ready         = ready_q;
  assign bus.busy          = busy_q;
  assign bus.vote_recorded = rec_q;
  assign bus.vote_reject   = rej_q;
  assign bus.recorded_cand = rec_cand_q;
  assign bus.count_out     = count_out_q;
endmodule
